// File: rtl/mux_scan.sv
// Registered N-channel mux with direct-select and self-stepping scan modes.
// Define MUX_SCAN_CONTINUOUS_EN to make scan mode repeat until mode=0 at the wrap.
module mux_scan #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 1,
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH*WIDTH-1:0]   muxin,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    input  logic                    start,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    sel_err
);

    // state     | meaning
    // S_IDLE    | direct streaming (mode=0) or waiting for start (mode=1)
    // S_DWELL   | settling on channel ch, cnt counts up to DWELL-1
    // S_PRESENT | channel ch sample held on the output until accepted
    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_PRESENT} state_t;

    localparam logic [7:0]       CNT_LAST = 8'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(N_CH - 1);

    state_t             state, state_nx;
    logic [SEL_W-1:0]   ch, ch_nx;
    logic [7:0]         cnt, cnt_nx;
    logic [WIDTH-1:0]   data_nx;
    logic [SEL_W-1:0]   och_nx;
    logic               valid_nx, busy_nx, sel_err_nx;
    logic [WIDTH-1:0]   sel_data, ch_data;
    logic               sel_oob, slot_free, accept;

    assign slot_free = !out_valid || out_ready;
    assign accept    = out_valid && out_ready;
    assign sel_oob   = 32'(sel) >= N_CH;

    // Out-of-range selects fall through the loop and read as zero.
    always_comb begin
        sel_data = '0;
        ch_data  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (32'(sel) == k) sel_data = muxin[k*WIDTH +: WIDTH];
            if (32'(ch) == k)  ch_data  = muxin[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ch        <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            ch        <= ch_nx;
            cnt       <= cnt_nx;
            out_data  <= data_nx;
            out_ch    <= och_nx;
            out_valid <= valid_nx;
            busy      <= busy_nx;
            sel_err   <= sel_err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ch_nx      = ch;
        cnt_nx     = cnt;
        data_nx    = out_data;
        och_nx     = out_ch;
        valid_nx   = out_valid && !out_ready;
        busy_nx    = busy;
        sel_err_nx = 1'b0;
        case (state)
            S_IDLE: begin
                if (!mode) begin
                    if (slot_free) begin
                        data_nx    = sel_data;
                        och_nx     = sel;
                        valid_nx   = 1'b1;
                        sel_err_nx = sel_oob;
                    end
                end else if (start) begin
                    state_nx = S_DWELL;
                    ch_nx    = '0;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                end
            end
            S_DWELL: begin
                // cnt saturates at the last value while a stale beat blocks the slot
                if (cnt == CNT_LAST) begin
                    if (slot_free) begin
                        data_nx  = ch_data;
                        och_nx   = ch;
                        valid_nx = 1'b1;
                        state_nx = S_PRESENT;
                    end
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            S_PRESENT: begin
                if (accept) begin
                    if (ch != CH_LAST) begin
                        ch_nx    = ch + 1'b1;
                        cnt_nx   = '0;
                        state_nx = S_DWELL;
                    end else begin
`ifdef MUX_SCAN_CONTINUOUS_EN
                        if (mode) begin
                            ch_nx    = '0;
                            cnt_nx   = '0;
                            state_nx = S_DWELL;
                        end else begin
                            state_nx = S_IDLE;
                            busy_nx  = 1'b0;
                        end
`else
                        state_nx = S_IDLE;
                        busy_nx  = 1'b0;
`endif
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: stimulus pushes expected beats, a negedge monitor pops them on accept.
module tb_mux_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] muxin;
    logic [3:0]  sel;
    logic        mode, start, out_ready;
    logic [3:0]  out_data;
    logic [3:0]  out_ch;
    logic        out_valid, busy, sel_err;

    typedef struct packed {
        logic [3:0] d;
        logic [3:0] c;
    } beat_t;

    beat_t exp_q[$];
    int    beat_cyc[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    start_cyc;

    // channel k carries k+5
    logic [3:0] ch_val [8] = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};

    mux_scan #(.N_CH(8), .WIDTH(4), .SEL_W(4), .DWELL(4)) dut (
        .clk(clk), .rst_n(rst_n), .muxin(muxin), .sel(sel), .mode(mode),
        .start(start), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .sel_err(sel_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] d, input logic [3:0] c);
        beat_t b;
        b.d = d;
        b.c = c;
        exp_q.push_back(b);
    endtask

    task automatic push_scan();
        for (int k = 0; k < 8; k++) push_exp(ch_val[k], 4'(k));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ch(input logic [3:0] c);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (out_valid === 1'b1 && out_ch == c) found = 1'b1;
        end
        check("wait_ch_found", 32'(found), 32'd1);
    endtask

    // mode goes back to 1 straight away so IDLE does not start direct loads
    task automatic wait_scan_end();
        for (int i = 0; i < 300 && busy === 1'b1; i++) step();
        mode = 1'b1;
        check("scan_end_busy", 32'(busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual_ch=%0h actual_data=%0h required=none", out_ch, out_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_data", 32'(out_data), 32'(e.d));
                check("beat_ch", 32'(out_ch), 32'(e.c));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; muxin = 32'hCBA98765; sel = 4'd0;
        mode = 1'b1; start = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ch", 32'(out_ch), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel_err", 32'(sel_err), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_valid", 32'(out_valid), 32'd0);

        // direct streaming, one beat per cycle
        out_ready = 1'b1; mode = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sel = 4'(k);
            push_exp(ch_val[k], 4'(k));
            step();
            check("direct_latency", 32'(out_data), 32'(ch_val[k]));
        end
        mode = 1'b1;
        step();
        check("direct_clear", 32'(out_valid), 32'd0);

        // backpressure holds the loaded beat while sel moves
        mode = 1'b0; out_ready = 1'b0; sel = 4'd2;
        push_exp(4'h7, 4'd2);
        step();
        check("bp_data0", 32'(out_data), 32'h7);
        sel = 4'd5;
        step();
        check("bp_data1", 32'(out_data), 32'h7);
        sel = 4'd6;
        step();
        check("bp_data2", 32'(out_data), 32'h7);
        check("bp_ch", 32'(out_ch), 32'd2);

        // out-of-range select
        sel = 4'd9; out_ready = 1'b1;
        push_exp(4'h0, 4'd9);
        step();
        check("oob_data", 32'(out_data), 32'd0);
        check("oob_ch", 32'(out_ch), 32'd9);
        check("oob_err", 32'(sel_err), 32'd1);
        mode = 1'b1;
        step();
        check("oob_err_pulse", 32'(sel_err), 32'd0);
        check("oob_clear", 32'(out_valid), 32'd0);

        // unstalled scan
        push_scan();
        beat_cyc.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc;
        check("scan_busy", 32'(busy), 32'd1);
`ifdef MUX_SCAN_CONTINUOUS_EN
        mode = 1'b0;
`endif
        wait_scan_end();
        check("scan_len", 32'(cyc - start_cyc), 32'd40);
        check("scan_beats", 32'(beat_cyc.size()), 32'd8);
        check("scan_first", 32'(beat_cyc[0] - start_cyc), 32'd4);
        check("scan_gap", 32'(beat_cyc[1] - beat_cyc[0]), 32'd5);
        check("scan_gap_last", 32'(beat_cyc[7] - beat_cyc[6]), 32'd5);
        step(); step();
        check("single_pass", 32'({busy, out_valid}), 32'd0);

        // stalled scan: ch=2 beat held for 10 cycles
        push_scan();
        beat_cyc.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc;
        mode = 1'b0;
        wait_ch(4'd2);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_hold", 32'({out_valid, out_ch, out_data}), 32'({1'b1, 4'd2, 4'h7}));
        end
        out_ready = 1'b1;
        wait_scan_end();
        check("stall_len", 32'(cyc - start_cyc), 32'd50);
        check("stall_beats", 32'(beat_cyc.size()), 32'd8);

`ifdef MUX_SCAN_CONTINUOUS_EN
        // continuous: wrap to ch=0, stop when mode=0 at second wrap
        push_scan();
        push_scan();
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc;
        wait_ch(4'd7);
        wait_ch(4'd0);
        check("cont_busy", 32'(busy), 32'd1);
        mode = 1'b0;
        wait_scan_end();
        check("cont_len", 32'(cyc - start_cyc), 32'd80);
`endif

        // asynchronous reset in the middle of the ch=3 beat
        push_scan();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_ch(4'd3);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_ch", 32'(out_ch), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step(); step();
        check("post_rst_idle", 32'({busy, out_valid}), 32'd0);
        mode = 1'b0; sel = 4'd4;
        push_exp(4'h9, 4'd4);
        step();
        check("post_rst_direct", 32'({out_valid, out_data}), 32'({1'b1, 4'h9}));
        mode = 1'b1;
        step();
        check("post_rst_clear", 32'(out_valid), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
